// File: rtl/wimax_mapper.sv
// rtl/wimax_mapper.sv - serial-bit to BPSK/QPSK/16-QAM/64-QAM constellation mapper
// Bits are gathered LSB-first per symbol; the mapped I/Q pair sits in a one-deep output register.
module wimax_mapper #(
   parameter int OUT_W = 16,
   parameter int ACC_W = 6
) (
   input  logic                    clk_100,
   input  logic                    Reset,
   input  logic [1:0]              mode_in,
   input  logic                    data_in,
   input  logic                    valid_interleaver,
   output logic                    ready_interleaver,
   input  logic                    ready_TOP_TB,
   output logic                    valid_TOP_TB,
   output logic signed [OUT_W-1:0] I_comp,
   output logic signed [OUT_W-1:0] Q_comp,
   output logic [1:0]              mode_out
);

   localparam int CNT_W = $clog2(ACC_W + 1);

   localparam logic signed [15:0] A_BPSK = 16'sd32767;
   localparam logic signed [15:0] A_QPSK = 16'sd23170;
   localparam logic signed [15:0] A16_1  = 16'sd10362;
   localparam logic signed [15:0] A16_3  = 16'sd31086;
   localparam logic signed [15:0] A64_1  = 16'sd4681;
   localparam logic signed [15:0] A64_3  = 16'sd14043;
   localparam logic signed [15:0] A64_5  = 16'sd23405;
   localparam logic signed [15:0] A64_7  = 16'sd32767;

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [1:0]              mode_q, mode_d;
   logic [ACC_W-1:0]        acc_q, acc_d;
   logic                    valid_q, valid_d;
   logic signed [OUT_W-1:0] i_q, i_d;
   logic signed [OUT_W-1:0] q_q, q_d;
   logic [1:0]              mode_out_q, mode_out_d;

   logic                    accept;
   logic                    last;
   logic [1:0]              sym_mode;
   logic [CNT_W-1:0]        sym_len;
   logic [CNT_W-1:0]        cnt_inc;
   logic [ACC_W-1:0]        bits_w;
   logic signed [15:0]      i_map;
   logic signed [15:0]      q_map;

   function automatic logic [CNT_W-1:0] bits_per_sym(input logic [1:0] m);
      case (m)
         2'b00:   return CNT_W'(1);
         2'b01:   return CNT_W'(2);
         2'b10:   return CNT_W'(4);
         default: return CNT_W'(6);
      endcase
   endfunction

   // Gray-coded axis levels; the first-arriving bit of the axis is the MSB of g.
   function automatic logic signed [15:0] lvl16(input logic [1:0] g);
      case (g)
         2'b00:   return -A16_3;
         2'b01:   return -A16_1;
         2'b11:   return A16_1;
         default: return A16_3;
      endcase
   endfunction

   function automatic logic signed [15:0] lvl64(input logic [2:0] g);
      case (g)
         3'b000:  return -A64_7;
         3'b001:  return -A64_5;
         3'b011:  return -A64_3;
         3'b010:  return -A64_1;
         3'b110:  return A64_1;
         3'b111:  return A64_3;
         3'b101:  return A64_5;
         default: return A64_7;
      endcase
   endfunction

   // Downstream stall blocks input so a completing symbol always finds the output register free.
   assign ready_interleaver = !Reset && !(valid_q && !ready_TOP_TB);
   assign accept            = valid_interleaver && ready_interleaver;
   assign sym_mode          = (cnt_q == '0) ? mode_in : mode_q;
   assign sym_len           = bits_per_sym(sym_mode);
   assign cnt_inc           = cnt_q + CNT_W'(1);
   assign last              = (cnt_inc == sym_len);

   always_comb begin
      bits_w = acc_q;
      for (int k = 0; k < ACC_W; k++) begin
         if (cnt_q == CNT_W'(k)) begin
            bits_w[k] = data_in;
         end
      end
   end

   always_comb begin
      i_map = '0;
      q_map = '0;
      case (sym_mode)
         2'b00: begin
            i_map = bits_w[0] ? -A_BPSK : A_BPSK;
         end
         2'b01: begin
            i_map = bits_w[0] ? -A_QPSK : A_QPSK;
            q_map = bits_w[1] ? -A_QPSK : A_QPSK;
         end
         2'b10: begin
            i_map = lvl16({bits_w[0], bits_w[1]});
            q_map = lvl16({bits_w[2], bits_w[3]});
         end
         default: begin
            i_map = lvl64({bits_w[0], bits_w[1], bits_w[2]});
            q_map = lvl64({bits_w[3], bits_w[4], bits_w[5]});
         end
      endcase
   end

   always_comb begin
      cnt_d      = cnt_q;
      mode_d     = mode_q;
      acc_d      = acc_q;
      valid_d    = valid_q;
      i_d        = i_q;
      q_d        = q_q;
      mode_out_d = mode_out_q;
      if (valid_q && ready_TOP_TB) begin
         valid_d = 1'b0;
      end
      if (accept) begin
         if (last) begin
            cnt_d      = '0;
            acc_d      = '0;
            valid_d    = 1'b1;
            i_d        = i_map[15 -: OUT_W];
            q_d        = q_map[15 -: OUT_W];
            mode_out_d = sym_mode;
         end else begin
            cnt_d  = cnt_inc;
            acc_d  = bits_w;
            mode_d = sym_mode;
         end
      end
   end

   always_ff @(posedge clk_100) begin
      if (Reset) begin
         cnt_q      <= '0;
         mode_q     <= '0;
         acc_q      <= '0;
         valid_q    <= 1'b0;
         i_q        <= '0;
         q_q        <= '0;
         mode_out_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         mode_q     <= mode_d;
         acc_q      <= acc_d;
         valid_q    <= valid_d;
         i_q        <= i_d;
         q_q        <= q_d;
         mode_out_q <= mode_out_d;
      end
   end

   assign valid_TOP_TB = valid_q;
   assign I_comp       = i_q;
   assign Q_comp       = q_q;
   assign mode_out     = mode_out_q;

endmodule
